// File: rtl/par2ser.sv
// par2ser: parallel-to-serial converter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it out one
// bit per clock on ser_o. ser_o comes straight from a flop. Words stream
// back-to-back with no idle cycle between frames.
//
// Optional feature: define PAR2SER_PARITY_EN to append an even-parity bit to
// every frame. Each frame is then WIDTH+1 bits, and last_o marks the parity
// bit. With the macro undefined, frames are WIDTH bits and last_o marks the
// final data bit.
//
// Parameters
//   WIDTH       data word width, 2..32
//   LSB_FIRST   0 = MSB sent first, 1 = LSB sent first
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   data_i       parallel word, captured only on an accept
//   valid_i      upstream offers data_i
//   ready_o      block can accept a word this cycle (decoded from state)
//   ser_o        serial bit (registered)
//   ser_valid_o  ser_o carries a frame bit
//   last_o       ser_o is the final bit of the frame
//   dbg_state_o  current FSM state (0 idle, 1 shift, 2 parity)
//
// Handshake: a word is accepted on a rising clk edge where valid_i and
// ready_o are both 1. While ready_o is 0, valid_i and data_i are ignored.
// The upstream holds valid_i and data_i stable until that edge.
module par2ser #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             last_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;  // bits still to send, next one at the head
  logic [CW-1:0]    cnt_q, cnt_d;      // bits remaining after the one on ser_o
  logic             ser_q, ser_d;
`ifdef PAR2SER_PARITY_EN
  logic             par_q, par_d;      // even parity of the captured word
`endif
  logic             accept;

  // The head of a word is the bit that goes out next.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] drop(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  assign accept = valid_i & ready_o;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
`ifdef PAR2SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. ser_d is the bit that ser_o shows in the next cycle.
  // The first bit of a new word is loaded directly into ser_q. This lets the
  // first bit appear one cycle after the accept, and it lets a new frame
  // follow the last bit of the previous frame without a gap.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
`ifdef PAR2SER_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          ser_d   = head(shreg_q);
          shreg_d = drop(shreg_q);
          cnt_d   = cnt_q - CW'(1);
        end else begin
`ifdef PAR2SER_PARITY_EN
          state_d = S_PARITY;
          ser_d   = par_q;
`else
          state_d = S_IDLE;
`endif
          shreg_d = '0;
        end
      end
      S_PARITY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase

    // An accept can only happen in a state that ends a frame or is idle.
    // Loading the new word therefore overrides whatever the case chose.
    if (accept) begin
      state_d = S_SHIFT;
      ser_d   = head(data_i);
      shreg_d = drop(data_i);
      cnt_d   = CW'(WIDTH - 1);
`ifdef PAR2SER_PARITY_EN
      par_d   = ^data_i;
`endif
    end
  end

  // Output decode
  always_comb begin
    ready_o     = 1'b0;
    last_o      = 1'b0;
    ser_valid_o = (state_q != S_IDLE);
    ser_o       = ser_q;
    dbg_state_o = state_q;
    case (state_q)
      S_IDLE: ready_o = 1'b1;
      S_SHIFT: begin
`ifndef PAR2SER_PARITY_EN
        ready_o = (cnt_q == '0);
        last_o  = (cnt_q == '0);
`endif
      end
      S_PARITY: begin
        ready_o = 1'b1;
        last_o  = 1'b1;
      end
      default: begin
        ready_o = 1'b0;
        last_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/par2ser.md
# par2ser

Parallel-to-serial converter that feeds the 4-bit serial-in shift register stage. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on a registered serial output, with a qualifier and a last-bit marker. Back-to-back words stream with no idle gap. An optional even-parity bit can be appended to each frame.

## Interface
- WIDTH, 4: data word width; legal range 2..32.
- LSB_FIRST, 0: 0 = MSB sent first; 1 = LSB sent first.

- clk  in  1  system clock; all flops update on the rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain only.
- data_i  in  WIDTH  parallel word; sampled only on handshake.
- valid_i  in  1  upstream has a word on data_i.
- ready_o  out  1  block can accept a word this cycle.
- ser_o  out  1  serial bit, registered; connects to the shift register's x_i.
- ser_valid_o  out  1  ser_o carries a frame bit this cycle.
- last_o  out  1  current ser_o bit is the final bit of the frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits going out; bit counter runs WIDTH-1 down to 0.
  - PARITY: parity bit going out; this state exists only with the macro.
- Handshake:
  - A word is accepted on a rising edge where valid_i=1 and ready_o=1.
  - data_i is captured into an internal WIDTH-bit shift register and the counter loads WIDTH-1.
  - valid_i or data_i activity while ready_o=0 is ignored; no capture occurs.
- ready_o is combinational from state. It is 1 in any of these cases:
  - state is IDLE;
  - state is SHIFT with counter=0 and parity is compiled out;
  - state is PARITY.
  - It is 0 in every other case.
- SHIFT:
  - Each cycle drives the next bit, in the order set by LSB_FIRST, and decrements the counter.
  - At counter=0 with no parity: an accept in this cycle re-enters SHIFT with the new word; otherwise the block goes to IDLE.
  - At counter=0 with parity: the block goes to PARITY.
- PARITY:
  - Drives p = XOR of all captured data bits, so the total count of ones in the frame is even.
  - Exits to SHIFT on an accept, otherwise to IDLE.
- last_o is 1 with the final frame bit: the last data bit, or the parity bit when parity is compiled in.
- With no frame bit being driven, ser_o=0, ser_valid_o=0 and last_o=0.
- Reset asserted (reset=0), at any time including mid-frame:
  - the frame is aborted immediately and asynchronously;
  - state goes to IDLE and the shift register and counter clear;
  - ser_o=0, ser_valid_o=0, last_o=0, ready_o=1.
  - No accept can occur while reset=0. A partial frame is never resumed.

## Timing
- Accept at edge k: first bit valid from edge k+1, bit i valid from edge k+1+i, last data bit from edge k+WIDTH, parity bit from edge k+WIDTH+1.
- Latency from accept to first bit: 1 cycle.
- Throughput: one word per WIDTH cycles, or WIDTH+1 with parity. No bubble between consecutive frames when valid_i stays high.
- ready_o is low for the first WIDTH-1 bit cycles of every frame (WIDTH cycles with parity). The upstream must hold valid_i and data_i until the handshake completes.
- Reset release: the first edge with reset=1 may accept a word.

## Configuration
- Macro PAR2SER_PARITY_EN.
- When defined:
  - PARITY state present; frames are WIDTH+1 bits with even parity last.
  - last_o marks the parity bit.
- When undefined:
  - PARITY state and parity logic are absent; frames are WIDTH bits.
  - last_o marks the last data bit.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-stream -> ser_o=0, ser_valid_o=0, last_o=0, ready_o=1 immediately and throughout.
- Single word, WIDTH=4, LSB_FIRST=0, data_i=4'b1011 accepted at edge k:
  - ser_o reads 1,0,1,1 on cycles k+1..k+4 with ser_valid_o=1;
  - last_o=1 only on k+4;
  - ready_o=0 on k+1..k+3 and ready_o=1 on k+4;
  - ser_valid_o=0 from k+5.
- Back-to-back streaming: valid_i held high with 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; last_o on bits 4 and 8; no gap.
- LSB_FIRST=1 with data_i=4'b0001 -> ser_o 1,0,0,0.
- Parity build (PAR2SER_PARITY_EN defined):
  - 4'b0111 -> ser_o 0,1,1,1 then 1, with last_o on the fifth bit;
  - 4'b0110 -> parity bit 0;
  - back-to-back frames are 5 cycles apart.
- Mid-frame reset: assert reset after 2 bits of 4'b1100, release, then send 4'b0011 -> ser_o 0,0,1,1 with no residue from the aborted frame.
